ptw: RTL and testbench

Sv32 hardware page-table walker that services TLB misses. It accepts a miss request with a VPN and an access type, then fetches level-1 and, if needed, level-0 PTEs through a single-outstanding memory read port. It checks the leaf PTE for format and A/D faults, writes the leaf into the TLB through the TLB's fill port (`cs`/`we`/`spage`/`pte_in`), and returns the result to the requester. It sits between the MMU miss path and the memory arbiter.

---
 rtl/ptw_pkg.sv | 46 ++++
 rtl/ptw_pte_check.sv | 60 ++++++
 rtl/ptw.sv | 188 ++++++++++++++++++
 tb/tb_ptw.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_pkg.sv
// ---------------------------------------------------------------------------
// ptw_pkg
// Shared definitions for the Sv32 page-table walker:
//   - walker state encoding
//   - PTE bit positions (V/R/W/X/U/G/A/D) and the PPN fields
//   - access-type codes carried on walk_acc
//   - helper that forms a PTE physical address from a table PPN and a
//     10-bit VPN index
// ---------------------------------------------------------------------------
package ptw_pkg;

    // Walker states. IDLE is the all-zero code so that reset lands there.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L1   = 2'd1,
        ST_L0   = 2'd2,
        ST_RESP = 2'd3
    } ptw_state_e;

    // PTE flag bit positions
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // PPN field: PTE[31:10]; PPN[0] sub-field: PTE[19:10]
    localparam int PTE_PPN_LSB  = 10;
    localparam int PTE_PPN_MSB  = 31;
    localparam int PTE_PPN0_MSB = 19;

    // walk_acc codes
    localparam logic [1:0] ACC_LOAD  = 2'b00;
    localparam logic [1:0] ACC_STORE = 2'b01;
    localparam logic [1:0] ACC_FETCH = 2'b10;

    // Physical address of a PTE: {table PPN, index, 2'b00}
    function automatic logic [33:0] pte_addr(input logic [21:0] ppn,
                                             input logic [9:0]  idx);
        return {ppn, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// ---------------------------------------------------------------------------
// ptw_pte_check
// Purely combinational classification of one PTE fetched by the walker.
//
// Ports
//   pte    in  32  PTE as returned by memory
//   level  in  1   1 = level-1 (root) table, 0 = level-0 table
//   acc    in  2   access type (load / store / fetch)
//   leaf   out 1   PTE is a leaf (R or X set)
//   pf     out 1   PTE raises a page fault at this level
//   spage  out 1   PTE is a leaf at level 1, i.e. a 4 MiB superpage
//
// Fault rules
//   - V=0, or W=1 with R=0                 -> page fault
//   - non-leaf at level 0                  -> page fault
//   - leaf at level 1 with PPN[0] != 0     -> page fault (misaligned)
//   - leaf with A=0, or store with D=0     -> page fault
//   A non-leaf at level 1 is not a fault; the walker descends.
// ---------------------------------------------------------------------------
module ptw_pte_check
    import ptw_pkg::*;
(
    input  logic [31:0] pte,
    input  logic        level,
    input  logic [1:0]  acc,
    output logic        leaf,
    output logic        pf,
    output logic        spage
);

    logic invalid;
    logic misaligned;
    logic ad_fault;

    // Bits this block does not need to classify the PTE.
    logic unused_pte_bits;
    assign unused_pte_bits = ^{pte[PTE_PPN_MSB:PTE_PPN0_MSB+1], pte[9:8],
                               pte[PTE_G], pte[PTE_U]};

    assign invalid    = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
    assign leaf       = pte[PTE_R] || pte[PTE_X];
    assign misaligned = level && (pte[PTE_PPN0_MSB:PTE_PPN_LSB] != 10'd0);
    // The walker never sets A or D itself; a clear bit is reported as a fault
    // so software can update the PTE and retry.
    assign ad_fault   = !pte[PTE_A] || ((acc == ACC_STORE) && !pte[PTE_D]);

    always_comb begin
        pf = 1'b0;
        if (invalid) begin
            pf = 1'b1;
        end else if (!leaf) begin
            pf = !level;
        end else begin
            pf = misaligned || ad_fault;
        end
    end

    assign spage = level && leaf;

endmodule

// File: rtl/ptw.sv
// ---------------------------------------------------------------------------
// ptw
// Sv32 hardware page-table walker servicing TLB misses. Accepts a miss
// (VPN + access type), reads the level-1 PTE and, when that is a pointer,
// the level-0 PTE through a single-outstanding read port, checks the leaf,
// fills the TLB and reports the result to the requester.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   walk_req/vpn/acc         miss request, accepted while walk_busy=0
//   walk_busy                high in every state except IDLE
//   satp_ppn                 root table PPN, sampled at acceptance
//   mem_req/mem_addr         PTE read request, held until mem_ack
//   mem_ack/rdata/err        read completion
//   tlb_cs/we/vpn/spage/pte  TLB fill port (pte written unmodified)
//   tlb_flush_req            TLB flush; kills the in-flight fill
//   walk_done/pf/af/pte      one-cycle completion and result
// ---------------------------------------------------------------------------
module ptw
    import ptw_pkg::*;
#(
    parameter int PPN_WIDTH   = 22,
    parameter int PADDR_WIDTH = 34
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   walk_req,
    input  logic [19:0]            walk_vpn,
    input  logic [1:0]             walk_acc,
    output logic                   walk_busy,
    input  logic [PPN_WIDTH-1:0]   satp_ppn,
    output logic                   mem_req,
    output logic [PADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_err,
    output logic                   tlb_cs,
    output logic                   tlb_we,
    output logic [19:0]            tlb_vpn,
    output logic                   tlb_spage,
    output logic [31:0]            tlb_pte,
    input  logic                   tlb_flush_req,
    output logic                   walk_done,
    output logic                   walk_pf,
    output logic                   walk_af,
    output logic [31:0]            walk_pte
);

    ptw_state_e state_reg;
    ptw_state_e state_next;

    logic [19:0]            vpn_reg;
    logic [1:0]             acc_reg;
    logic [PADDR_WIDTH-1:0] addr_reg;
    logic [31:0]            pte_reg;
    logic                   pf_reg;
    logic                   af_reg;
    logic                   spage_reg;
    logic                   flush_reg;   // a flush was seen during this walk

    logic chk_leaf;
    logic chk_pf;
    logic chk_spage;
    logic fetch_phase;
    logic fill;

    assign fetch_phase = (state_reg == ST_L1) || (state_reg == ST_L0);

    ptw_pte_check u_pte_check (
        .pte   (mem_rdata),
        .level (state_reg == ST_L1),
        .acc   (acc_reg),
        .leaf  (chk_leaf),
        .pf    (chk_pf),
        .spage (chk_spage)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (walk_req) begin
                    state_next = ST_L1;
                end
            end
            ST_L1: begin
                if (mem_ack) begin
                    // A clean non-leaf at level 1 is the only way to L0.
                    if (!mem_err && !chk_pf && !chk_leaf) begin
                        state_next = ST_L0;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_L0: begin
                if (mem_ack) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and walk datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            vpn_reg   <= '0;
            acc_reg   <= ACC_LOAD;
            addr_reg  <= '0;
            pte_reg   <= '0;
            pf_reg    <= 1'b0;
            af_reg    <= 1'b0;
            spage_reg <= 1'b0;
            flush_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == ST_IDLE) begin
                if (walk_req) begin
                    vpn_reg   <= walk_vpn;
                    acc_reg   <= walk_acc;
                    // satp_ppn is only needed to form the level-1 address,
                    // so it is captured there rather than in its own register.
                    addr_reg  <= PADDR_WIDTH'({satp_ppn, walk_vpn[19:10], 2'b00});
                    pf_reg    <= 1'b0;
                    af_reg    <= 1'b0;
                    spage_reg <= 1'b0;
                    flush_reg <= tlb_flush_req;
                end
            end else begin
                // Sticky until the next acceptance.
                flush_reg <= flush_reg | tlb_flush_req;
            end

            if (fetch_phase && mem_ack) begin
                pte_reg <= mem_rdata;
                if (mem_err) begin
                    af_reg <= 1'b1;
                end else if (chk_pf) begin
                    pf_reg <= 1'b1;
                end else if (!chk_leaf) begin
                    // Pointer to the level-0 table: retarget the request now
                    // so the L0 read starts the very next cycle.
                    addr_reg <= PADDR_WIDTH'({PPN_WIDTH'(mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB]),
                                              vpn_reg[9:0], 2'b00});
                end else begin
                    spage_reg <= chk_spage;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: state-decoded strobes, registered data
    // -----------------------------------------------------------------------
    // The fill is also suppressed by a flush arriving in the RESP cycle itself,
    // hence the direct use of tlb_flush_req here.
    assign fill      = (state_reg == ST_RESP) && !pf_reg && !af_reg &&
                       !flush_reg && !tlb_flush_req;

    assign walk_busy = (state_reg != ST_IDLE);
    assign mem_req   = fetch_phase;
    assign mem_addr  = addr_reg;

    assign tlb_cs    = fill;
    assign tlb_we    = fill;
    assign tlb_vpn   = vpn_reg;
    assign tlb_spage = spage_reg;
    assign tlb_pte   = pte_reg;

    assign walk_done = (state_reg == ST_RESP);
    assign walk_pf   = (state_reg == ST_RESP) && pf_reg;
    assign walk_af   = (state_reg == ST_RESP) && af_reg;
    assign walk_pte  = pte_reg;

endmodule

// File: tb/tb_ptw.sv
// ---------------------------------------------------------------------------
// tb_ptw
// Self-checking bench for the Sv32 page-table walker: directed walks from the
// test plan plus randomized walks checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        walk_req;
    logic [19:0] walk_vpn;
    logic [1:0]  walk_acc;
    logic        walk_busy;
    logic [21:0] satp_ppn;
    logic        mem_req;
    logic [33:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        tlb_cs;
    logic        tlb_we;
    logic [19:0] tlb_vpn;
    logic        tlb_spage;
    logic [31:0] tlb_pte;
    logic        tlb_flush_req;
    logic        walk_done;
    logic        walk_pf;
    logic        walk_af;
    logic [31:0] walk_pte;

    always #5 clk = ~clk;

    ptw #(.PPN_WIDTH(22), .PADDR_WIDTH(34)) dut (
        .clk           (clk),
        .rst           (rst),
        .walk_req      (walk_req),
        .walk_vpn      (walk_vpn),
        .walk_acc      (walk_acc),
        .walk_busy     (walk_busy),
        .satp_ppn      (satp_ppn),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .tlb_cs        (tlb_cs),
        .tlb_we        (tlb_we),
        .tlb_vpn       (tlb_vpn),
        .tlb_spage     (tlb_spage),
        .tlb_pte       (tlb_pte),
        .tlb_flush_req (tlb_flush_req),
        .walk_done     (walk_done),
        .walk_pf       (walk_pf),
        .walk_af       (walk_af),
        .walk_pte      (walk_pte)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observations gathered while a walk is driven
    logic [33:0] obs_l1_addr;
    logic [33:0] obs_l0_addr;
    int          obs_nreq;
    bit          obs_unstable;
    bit          obs_gap;
    bit          obs_both;
    int          obs_done_cyc;
    logic        obs_pf, obs_af, obs_we, obs_cs, obs_spage;
    logic [31:0] obs_pte;
    logic [19:0] obs_vpn;

    // Expected outcome of one walk
    typedef struct packed {
        bit          descend;
        bit          pf;
        bit          af;
        bit          spage;
        bit          fill;
        logic [33:0] l1_addr;
        logic [33:0] l0_addr;
        int          done_cyc;
        logic [31:0] leaf_pte;
    } exp_t;

    // ---------------------------------------------------------------------
    // Reference model (Sv32 rules, plain arithmetic)
    // ---------------------------------------------------------------------
    function automatic bit pte_ok(input logic [31:0] p);
        return (p[0] == 1'b1) && !((p[2] == 1'b1) && (p[1] == 1'b0));
    endfunction

    function automatic bit pte_leaf(input logic [31:0] p);
        return (p[1] == 1'b1) || (p[3] == 1'b1);
    endfunction

    function automatic bit ad_ok(input logic [31:0] p, input logic [1:0] acc);
        return (p[6] == 1'b1) && !((acc == 2'b01) && (p[7] == 1'b0));
    endfunction

    function automatic exp_t model(input logic [21:0] satp, input logic [19:0] vpn,
                                   input logic [1:0] acc,
                                   input logic [31:0] p1, input bit e1, input int w1,
                                   input logic [31:0] p0, input bit e0, input int w0,
                                   input int flush_at);
        exp_t   e;
        longint ppn1;
        e = '0;
        ppn1 = longint'(p1) / 1024;
        e.l1_addr = 34'(longint'(satp) * 4096 + (longint'(vpn) / 1024) * 4);
        e.l0_addr = 34'(ppn1 * 4096 + (longint'(vpn) % 1024) * 4);
        e.done_cyc = 2 + w1;
        e.leaf_pte = p1;
        if (e1) begin
            e.af = 1'b1;
        end else if (!pte_ok(p1)) begin
            e.pf = 1'b1;
        end else if (!pte_leaf(p1)) begin
            e.descend  = 1'b1;
            e.done_cyc = 3 + w1 + w0;
            e.leaf_pte = p0;
            if (e0) e.af = 1'b1;
            else if (!pte_ok(p0) || !pte_leaf(p0) || !ad_ok(p0, acc)) e.pf = 1'b1;
        end else begin
            if ((ppn1 % 1024) != 0 || !ad_ok(p1, acc)) e.pf = 1'b1;
            else e.spage = 1'b1;
        end
        e.fill = !e.pf && !e.af && !((flush_at >= 1) && (flush_at <= e.done_cyc));
        return e;
    endfunction

    // ---------------------------------------------------------------------
    // Walk driver: presents a request, acts as the memory (wait states,
    // data, error) and records what the walker did. Starts and ends at #1
    // after a rising edge with the walker idle.
    // ---------------------------------------------------------------------
    task automatic drive_walk(input logic [21:0] satp, input logic [19:0] vpn,
                              input logic [1:0] acc,
                              input logic [31:0] p1, input bit e1, input int w1,
                              input logic [31:0] p0, input bit e0, input int w0,
                              input int flush_at);
        int          nack = 0;
        int          wcnt = 0;
        bit          in_req = 1'b0;
        bit          prev_ack = 1'b0;
        logic [33:0] cur_addr = '0;
        obs_l1_addr = '0; obs_l0_addr = '0; obs_nreq = 0; obs_unstable = 1'b0;
        obs_gap = 1'b0; obs_both = 1'b0; obs_done_cyc = -1;
        obs_pf = 1'b0; obs_af = 1'b0; obs_we = 1'b0; obs_cs = 1'b0; obs_spage = 1'b0;
        obs_pte = '0; obs_vpn = '0;

        walk_req = 1'b1; walk_vpn = vpn; walk_acc = acc; satp_ppn = satp;
        @(posedge clk);                       // acceptance: cycle 0
        #1;
        walk_req = 1'b0; walk_vpn = 20'($urandom); satp_ppn = 22'($urandom);
        walk_acc = 2'($urandom_range(0, 2));
        for (int cyc = 1; cyc <= 60; cyc++) begin
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
            tlb_flush_req = (cyc == flush_at);
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1; wcnt = 0; cur_addr = mem_addr;
                    if (nack == 0) obs_l1_addr = mem_addr;
                    else if (nack == 1) begin
                        obs_l0_addr = mem_addr;
                        obs_gap = !prev_ack;
                    end
                    obs_nreq++;
                end else if (mem_addr !== cur_addr) begin
                    obs_unstable = 1'b1;
                end
                if (wcnt == ((nack == 0) ? w1 : w0)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (nack == 0) ? p1 : p0;
                    mem_err   = (nack == 0) ? e1 : e0;
                end else begin
                    wcnt++;
                end
            end
            #1;
            if (walk_pf && walk_af) obs_both = 1'b1;
            if (walk_done) begin
                obs_done_cyc = cyc; obs_pf = walk_pf; obs_af = walk_af;
                obs_we = tlb_we; obs_cs = tlb_cs; obs_spage = tlb_spage;
                obs_pte = walk_pte; obs_vpn = tlb_vpn;
            end
            prev_ack = mem_ack;
            if (mem_ack) begin
                nack++;
                in_req = 1'b0;
            end
            if (walk_done) break;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0; mem_err = 1'b0; tlb_flush_req = 1'b0;
        @(posedge clk);                       // back to IDLE
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({walk_busy, mem_req, mem_addr, tlb_cs, tlb_we, tlb_vpn, tlb_spage, tlb_pte,
             walk_done, walk_pf, walk_af, walk_pte} !== '0)
            $display("FAIL reset_outputs: busy=%b req=%b addr=%h we=%b done=%b pte=%h, want all zero",
                     walk_busy, mem_req, mem_addr, tlb_we, walk_done, walk_pte);
        else pass_cnt++;
        rst = 1'b0;
        // Acks while idle are ignored
        mem_ack = 1'b1; mem_rdata = 32'h000400CF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (walk_done !== 1'b0 || walk_busy !== 1'b0)
                $display("FAIL idle_ack: done=%b busy=%b, want 0 0", walk_done, walk_busy);
            else pass_cnt++;
        end
        mem_ack = 1'b0;
        $display("reset: idle outputs and stray acks checked");
    endtask

    task automatic test_4k_walk();
        drive_walk(22'h00100, 20'h12345, 2'b00, 32'h08000401, 1'b0, 0,
                   32'h000400CF, 1'b0, 0, -1);
        $display("4k walk: l1=%h l0=%h done@%0d we=%b pte=%h", obs_l1_addr, obs_l0_addr,
                 obs_done_cyc, obs_we, obs_pte);
        total_cnt++;
        if (obs_l1_addr !== 34'h000100120) $display("FAIL 4k_l1_addr: got %h want 000100120", obs_l1_addr);
        else pass_cnt++;
        total_cnt++;
        if (obs_l0_addr !== 34'h020001D14) $display("FAIL 4k_l0_addr: got %h want 020001d14", obs_l0_addr);
        else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc !== 3) $display("FAIL 4k_latency: got %0d want 3", obs_done_cyc);
        else pass_cnt++;
        total_cnt++;
        if ({obs_we, obs_cs, obs_spage, obs_pf, obs_af} !== 5'b11000)
            $display("FAIL 4k_flags: got we/cs/spage/pf/af=%b want 11000",
                     {obs_we, obs_cs, obs_spage, obs_pf, obs_af});
        else pass_cnt++;
        total_cnt++;
        if (obs_pte !== 32'h000400CF || obs_vpn !== 20'h12345)
            $display("FAIL 4k_fill_data: got pte=%h vpn=%h want 000400cf 12345", obs_pte, obs_vpn);
        else pass_cnt++;
        total_cnt++;
        if (obs_gap !== 1'b0) $display("FAIL 4k_no_gap: got gap=%b want 0", obs_gap);
        else pass_cnt++;
    endtask

    task automatic test_superpage();
        drive_walk(22'h00100, 20'h12345, 2'b00, 32'h200000CF, 1'b0, 0,
                   32'h0, 1'b0, 0, -1);
        $display("superpage: nreq=%0d done@%0d spage=%b we=%b", obs_nreq, obs_done_cyc,
                 obs_spage, obs_we);
        total_cnt++;
        if (obs_nreq !== 1 || obs_done_cyc !== 2)
            $display("FAIL spage_latency: got nreq=%0d done=%0d want 1 2", obs_nreq, obs_done_cyc);
        else pass_cnt++;
        total_cnt++;
        if ({obs_spage, obs_we, obs_pf, obs_af} !== 4'b1100 || obs_pte !== 32'h200000CF)
            $display("FAIL spage_fill: got spage/we/pf/af=%b pte=%h want 1100 200000cf",
                     {obs_spage, obs_we, obs_pf, obs_af}, obs_pte);
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
        drive_walk(22'h00100, 20'h12345, 2'b00, 32'h200004CF, 1'b0, 0,
                   32'h0, 1'b0, 0, -1);
        $display("misaligned superpage: pf=%b we=%b done@%0d", obs_pf, obs_we, obs_done_cyc);
        total_cnt++;
        if ({obs_pf, obs_af, obs_we, obs_cs} !== 4'b1000 || obs_done_cyc !== 2)
            $display("FAIL misaligned: got pf/af/we/cs=%b done=%0d want 1000 2",
                     {obs_pf, obs_af, obs_we, obs_cs}, obs_done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_dbit();
        drive_walk(22'h00100, 20'h12345, 2'b01, 32'h08000401, 1'b0, 0,
                   32'h0004004F, 1'b0, 0, -1);
        $display("store D=0: pf=%b we=%b", obs_pf, obs_we);
        total_cnt++;
        if ({obs_pf, obs_af, obs_we} !== 3'b100)
            $display("FAIL dbit_store: got pf/af/we=%b want 100", {obs_pf, obs_af, obs_we});
        else pass_cnt++;
        drive_walk(22'h00100, 20'h12345, 2'b00, 32'h08000401, 1'b0, 0,
                   32'h0004004F, 1'b0, 0, -1);
        $display("load D=0: pf=%b we=%b", obs_pf, obs_we);
        total_cnt++;
        if ({obs_pf, obs_af, obs_we} !== 3'b001 || obs_pte !== 32'h0004004F)
            $display("FAIL dbit_load: got pf/af/we=%b pte=%h want 001 0004004f",
                     {obs_pf, obs_af, obs_we}, obs_pte);
        else pass_cnt++;
    endtask

    task automatic test_err_wait();
        drive_walk(22'h00100, 20'h12345, 2'b00, 32'h08000401, 1'b0, 2,
                   32'h000400CF, 1'b1, 3, -1);
        $display("L0 bus error after waits: af=%b pf=%b done@%0d stable=%b", obs_af, obs_pf,
                 obs_done_cyc, !obs_unstable);
        total_cnt++;
        if (obs_unstable !== 1'b0) $display("FAIL err_addr_stable: got unstable=1 want 0");
        else pass_cnt++;
        total_cnt++;
        if ({obs_af, obs_pf, obs_we} !== 3'b100 || obs_done_cyc !== 8)
            $display("FAIL err_result: got af/pf/we=%b done=%0d want 100 8",
                     {obs_af, obs_pf, obs_we}, obs_done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        drive_walk(22'h00100, 20'h12345, 2'b00, 32'h08000401, 1'b0, 2,
                   32'h000400CF, 1'b0, 0, 1);
        $display("flush during L1 wait: done@%0d we=%b pte=%h", obs_done_cyc, obs_we, obs_pte);
        total_cnt++;
        if (obs_done_cyc !== 5 || obs_pte !== 32'h000400CF)
            $display("FAIL flush_done: got done=%0d pte=%h want 5 000400cf", obs_done_cyc, obs_pte);
        else pass_cnt++;
        total_cnt++;
        if ({obs_we, obs_cs, obs_pf, obs_af} !== 4'b0000)
            $display("FAIL flush_nofill: got we/cs/pf/af=%b want 0000", {obs_we, obs_cs, obs_pf, obs_af});
        else pass_cnt++;
    endtask

    task automatic test_rst_midwalk();
        bit seen_done = 1'b0;
        walk_req = 1'b1; walk_vpn = 20'h12345; walk_acc = 2'b00; satp_ppn = 22'h00100;
        @(posedge clk);
        #1;
        walk_req = 1'b0;
        mem_ack = 1'b1; mem_err = 1'b0; mem_rdata = 32'h08000401;   // L1 pointer
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 34'h020001D14)
            $display("FAIL rst_l0_req: got req=%b addr=%h want 1 020001d14", mem_req, mem_addr);
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if (walk_busy !== 1'b0 || mem_req !== 1'b0 || walk_done !== 1'b0)
            $display("FAIL rst_idle: got busy=%b req=%b done=%b want 0 0 0", walk_busy, mem_req, walk_done);
        else pass_cnt++;
        mem_ack = 1'b1; mem_rdata = 32'h000400CF;                   // late ack
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (walk_done || walk_busy) seen_done = 1'b1;
        end
        mem_ack = 1'b0;
        total_cnt++;
        if (seen_done !== 1'b0) $display("FAIL rst_late_ack: walker reacted, want no activity");
        else pass_cnt++;
        $display("reset mid-walk: busy=%b after late ack", walk_busy);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [21:0] satp, ppn;
            logic [19:0] vpn;
            logic [1:0]  acc;
            logic [7:0]  fl;
            logic [31:0] p1, p0;
            bit          e1, e0;
            int          w1, w0, fa;
            exp_t        e;
            satp = 22'($urandom); vpn = 20'($urandom); acc = 2'($urandom_range(0, 2));
            ppn = 22'($urandom); fl = 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1: fl = (fl & 8'hF1) | 8'h01;                  // pointer
                2: begin
                    fl = fl | 8'h43;                               // leaf, A set
                    if ($urandom_range(0, 1) == 0) ppn[9:0] = '0;  // aligned
                end
                default: ;
            endcase
            p1 = {ppn, 2'($urandom), fl};
            fl = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fl = fl | 8'h43;
            p0 = {22'($urandom), 2'($urandom), fl};
            e1 = ($urandom_range(0, 9) == 0);
            e0 = ($urandom_range(0, 9) == 0);
            w1 = $urandom_range(0, 3);
            w0 = $urandom_range(0, 3);
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : -1;
            e = model(satp, vpn, acc, p1, e1, w1, p0, e0, w0, fa);
            drive_walk(satp, vpn, acc, p1, e1, w1, p0, e0, w0, fa);
            $display("rand %0d: vpn=%h acc=%0d p1=%h p0=%h done@%0d pf=%b af=%b we=%b spage=%b",
                     n, vpn, acc, p1, p0, obs_done_cyc, obs_pf, obs_af, obs_we, obs_spage);
            total_cnt++;
            if (obs_l1_addr !== e.l1_addr || obs_unstable !== 1'b0)
                $display("FAIL rand_l1_addr: got %h unstable=%b want %h", obs_l1_addr, obs_unstable, e.l1_addr);
            else pass_cnt++;
            total_cnt++;
            if (obs_nreq !== (e.descend ? 2 : 1) || obs_done_cyc !== e.done_cyc)
                $display("FAIL rand_timing: got nreq=%0d done=%0d want %0d %0d",
                         obs_nreq, obs_done_cyc, e.descend ? 2 : 1, e.done_cyc);
            else pass_cnt++;
            if (e.descend) begin
                total_cnt++;
                if (obs_l0_addr !== e.l0_addr || obs_gap !== 1'b0)
                    $display("FAIL rand_l0_addr: got %h gap=%b want %h", obs_l0_addr, obs_gap, e.l0_addr);
                else pass_cnt++;
            end
            total_cnt++;
            if ({obs_pf, obs_af, obs_we, obs_cs, obs_spage, obs_both} !=
                {e.pf, e.af, e.fill, e.fill, e.spage, 1'b0})
                $display("FAIL rand_result: got pf/af/we/cs/spage/both=%b want %b",
                         {obs_pf, obs_af, obs_we, obs_cs, obs_spage, obs_both},
                         {e.pf, e.af, e.fill, e.fill, e.spage, 1'b0});
            else pass_cnt++;
            if (!e.af) begin
                total_cnt++;
                if (obs_pte !== e.leaf_pte || obs_vpn !== vpn)
                    $display("FAIL rand_pte: got pte=%h vpn=%h want %h %h", obs_pte, obs_vpn, e.leaf_pte, vpn);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; walk_req = 1'b0; walk_vpn = '0; walk_acc = '0; satp_ppn = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; tlb_flush_req = 1'b0;
        test_reset();
        test_4k_walk();
        test_superpage();
        test_misaligned();
        test_dbit();
        test_err_wait();
        test_flush();
        test_rst_midwalk();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
